// File: rtl/framebuf_pkg.sv
// Shared types and burst timing for the frame-buffer arbiter.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package framebuf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_BURST = 2'd2
    } state_t;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_t;

    localparam int DEF_BURST_LEN       = 16;
    localparam int DEF_MEM_RD_LAT      = 2;
    // A write burst needs one extra cycle because FIFO data lags the pop by one.
    localparam int DEF_WR_BURST_CYCLES = DEF_BURST_LEN + 1;
    // A read burst stays open until the last read word has drained from memory.
    localparam int DEF_RD_BURST_CYCLES = DEF_BURST_LEN + DEF_MEM_RD_LAT;

    function automatic int wr_burst_cycles(input int burst_len);
        return burst_len + 1;
    endfunction

    function automatic int rd_burst_cycles(input int burst_len, input int rd_lat);
        return burst_len + rd_lat;
    endfunction

endpackage

// File: rtl/framebuf_arbiter_if.sv
// Single-port frame-buffer memory bus between the arbiter and the memory.
// Latency: read data returns MEM_RD_LAT cycles after an enable with we=0.
// Backpressure: none; the memory accepts one access every cycle.
interface framebuf_arbiter_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 20
);
    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata;

    modport master (
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata
    );

    modport slave (
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_rdata
    );
endinterface

// File: rtl/frame_addr_gen.sv
// In-frame offset counter: clears on request, increments per access, saturates at FRAME_WORDS.
// Latency: offset updates on the clock edge after i_inc / i_clr.
// Backpressure: increments are ignored once the frame is full.
module frame_addr_gen
    import framebuf_pkg::*;
#(
    parameter int OFF_W       = 19,
    parameter int FRAME_WORDS = 307200
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [OFF_W-1:0] o_off,
    output logic             o_full
);
    localparam logic [OFF_W-1:0] OFF_END = OFF_W'(FRAME_WORDS);

    logic [OFF_W-1:0] off_q;
    logic [OFF_W-1:0] off_d;

    // Next offset: clear wins, otherwise count up until the frame end.
    always_comb begin
        off_d = off_q;
        if (i_clr) begin
            off_d = '0;
        end else if (i_inc && !o_full) begin
            off_d = off_q + OFF_W'(1);
        end
    end

    // Offset register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            off_q <= '0;
        end else begin
            off_q <= off_d;
        end
    end

    assign o_off  = off_q;
    assign o_full = (off_q == OFF_END);
endmodule

// File: rtl/framebuf_arbiter.sv
// Round-robin burst arbiter sharing one frame-buffer memory between camera writes and display reads.
// Latency: burst starts one cycle after grant; read data reaches the display FIFO MEM_RD_LAT cycles after each read.
// Backpressure: a burst is granted only when the FIFO level/free space covers a whole burst.
module framebuf_arbiter
    import framebuf_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int OFF_W       = 19,
    parameter int FRAME_WORDS = 307200,
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int LVL_W       = 10,
    parameter int MEM_RD_LAT  = DEF_MEM_RD_LAT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_sof,
    input  logic [LVL_W-1:0]  i_wr_level,
    output logic              o_wr_fifo_rd,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_frame_req,
    input  logic [LVL_W-1:0]  i_rd_free,
    output logic              o_rd_fifo_wr,
    output logic [DATA_W-1:0] o_rd_fifo_data,
    framebuf_arbiter_if.master mem,
    output logic              o_wr_frame_done,
    output logic              o_rd_bank
);
    localparam int WR_CYC = wr_burst_cycles(BURST_LEN);
    localparam int RD_CYC = rd_burst_cycles(BURST_LEN, MEM_RD_LAT);
    localparam int CNT_W  = $clog2(RD_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_B       = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_LAT     = CNT_W'(MEM_RD_LAT);
    localparam logic [CNT_W-1:0] CNT_LAT_END = CNT_W'(MEM_RD_LAT + BURST_LEN);
    localparam logic [CNT_W-1:0] WR_LAST     = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST     = CNT_W'(RD_CYC - 1);
    localparam logic [LVL_W-1:0] LVL_B       = LVL_W'(BURST_LEN);
    localparam logic [OFF_W-1:0] OFF_LAST    = OFF_W'(FRAME_WORDS - 1);

    state_t           state_q, state_d;
    grant_t           last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic wr_bank_q, done_bank_q, rd_bank_q, rd_armed_q;
    logic sof_pend_q, req_pend_q, done_q;

    logic [OFF_W-1:0] wr_off, rd_off;
    logic             wr_full, rd_full;

    logic in_idle, apply_sof, apply_req;
    logic wr_elig, rd_elig, take_rd, take_wr;
    logic wr_pop, wr_write, rd_read, rd_push, frame_end;

    assign in_idle   = (state_q == ST_IDLE);
    assign apply_sof = in_idle && sof_pend_q;
    assign apply_req = in_idle && req_pend_q;

    assign wr_elig = (i_wr_level >= LVL_B);
    assign rd_elig = rd_armed_q && !rd_full && (i_rd_free >= LVL_B);
    // On a tie the side that did not get the previous burst wins.
    assign take_rd = rd_elig && (!wr_elig || (last_grant_q == GNT_WR));
    assign take_wr = wr_elig && !take_rd;

    // Pops lead the memory writes by one cycle; a full frame still drains the FIFO.
    assign wr_pop    = (state_q == ST_WR_BURST) && (cnt_q < CNT_B);
    assign wr_write  = (state_q == ST_WR_BURST) && (cnt_q != '0) && !wr_full;
    assign rd_read   = (state_q == ST_RD_BURST) && (cnt_q < CNT_B) && !rd_full;
    assign rd_push   = (state_q == ST_RD_BURST) && (cnt_q >= CNT_LAT) && (cnt_q < CNT_LAT_END);
    assign frame_end = wr_write && (wr_off == OFF_LAST);

    frame_addr_gen #(.OFF_W(OFF_W), .FRAME_WORDS(FRAME_WORDS)) u_wr_addr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (apply_sof),
        .i_inc  (wr_write),
        .o_off  (wr_off),
        .o_full (wr_full)
    );

    frame_addr_gen #(.OFF_W(OFF_W), .FRAME_WORDS(FRAME_WORDS)) u_rd_addr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (apply_req),
        .i_inc  (rd_read),
        .o_off  (rd_off),
        .o_full (rd_full)
    );

    // Burst FSM next state: grant in IDLE, then run the fixed-length burst back to IDLE.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (take_rd) begin
                    state_d      = ST_RD_BURST;
                    last_grant_d = GNT_RD;
                end else if (take_wr) begin
                    state_d      = ST_WR_BURST;
                    last_grant_d = GNT_WR;
                end
            end
            ST_WR_BURST: begin
                if (cnt_q == WR_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_RD_BURST: begin
                if (cnt_q == RD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state register; reset aborts any burst in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= GNT_WR;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Frame sync: sticky requests, applied only in IDLE; bank ping-pong and frame-done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sof_pend_q  <= 1'b0;
            req_pend_q  <= 1'b0;
            done_q      <= 1'b0;
            wr_bank_q   <= 1'b0;
            done_bank_q <= 1'b1;
            rd_bank_q   <= 1'b0;
            rd_armed_q  <= 1'b0;
        end else begin
            sof_pend_q <= i_wr_sof | (sof_pend_q & ~apply_sof);
            req_pend_q <= i_rd_frame_req | (req_pend_q & ~apply_req);
            done_q     <= frame_end;
            if (frame_end) begin
                done_bank_q <= wr_bank_q;
            end
            // An incomplete frame restarts in the same bank.
            if (apply_sof && wr_full) begin
                wr_bank_q <= ~wr_bank_q;
            end
            // The read side picks up the last completed bank as it stood before any same-cycle SOF.
            if (apply_req) begin
                rd_bank_q  <= done_bank_q;
                rd_armed_q <= 1'b1;
            end else if (rd_full) begin
                rd_armed_q <= 1'b0;
            end
        end
    end

    assign o_wr_fifo_rd    = wr_pop;
    assign o_rd_fifo_wr    = rd_push;
    assign o_rd_fifo_data  = rd_push ? mem.i_mem_rdata : '0;
    assign o_wr_frame_done = done_q;
    assign o_rd_bank       = rd_bank_q;

    assign mem.o_mem_en    = wr_write | rd_read;
    assign mem.o_mem_we    = wr_write;
    assign mem.o_mem_addr  = wr_write ? {wr_bank_q, wr_off} :
                             rd_read  ? {rd_bank_q, rd_off} : '0;
    assign mem.o_mem_wdata = wr_write ? i_wr_data : '0;
endmodule

// File: tb/tb_framebuf_arbiter.sv
// Directed bench for framebuf_arbiter with a small frame (64 words) so whole frames fit in a short run.
// Latency: camera FIFO model returns data one cycle after a pop; memory model has 2-cycle read latency.
// Backpressure: FIFO level/free inputs are driven directly by the scenarios.
module tb_framebuf_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_sof;
    logic [9:0]  wr_level;
    logic        wr_fifo_rd;
    logic [11:0] wr_data = 12'h000;
    logic        rd_frame_req;
    logic [9:0]  rd_free;
    logic        rd_fifo_wr;
    logic [11:0] rd_fifo_data;
    logic        wr_frame_done;
    logic        rd_bank;

    int n_tot = 0;
    int n_bad = 0;
    int pop_cnt = 0;
    int base0 = 0;
    int base1 = 0;

    framebuf_arbiter_if #(.DATA_W(12), .ADDR_W(20)) mem_if ();

    framebuf_arbiter #(
        .DATA_W(12), .OFF_W(19), .FRAME_WORDS(64),
        .BURST_LEN(16), .LVL_W(10), .MEM_RD_LAT(2)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_wr_sof        (wr_sof),
        .i_wr_level      (wr_level),
        .o_wr_fifo_rd    (wr_fifo_rd),
        .i_wr_data       (wr_data),
        .i_rd_frame_req  (rd_frame_req),
        .i_rd_free       (rd_free),
        .o_rd_fifo_wr    (rd_fifo_wr),
        .o_rd_fifo_data  (rd_fifo_data),
        .mem             (mem_if),
        .o_wr_frame_done (wr_frame_done),
        .o_rd_bank       (rd_bank)
    );

    always #5 clk = ~clk;

    // Camera FIFO model: word value is the running pop count.
    always @(posedge clk) begin
        if (wr_fifo_rd === 1'b1) begin
            wr_data <= 12'(pop_cnt);
            pop_cnt <= pop_cnt + 1;
        end
    end

    // Memory model: two banks of 64 words, two-stage read pipeline.
    logic [11:0] mem_arr [0:127];
    logic [11:0] rd_p1;
    logic [6:0]  mem_idx;
    assign mem_idx = {mem_if.o_mem_addr[19], mem_if.o_mem_addr[5:0]};
    always @(posedge clk) begin
        if (mem_if.o_mem_en === 1'b1 && mem_if.o_mem_we === 1'b1) mem_arr[mem_idx] <= mem_if.o_mem_wdata;
        if (mem_if.o_mem_en === 1'b1 && mem_if.o_mem_we === 1'b0) rd_p1 <= mem_arr[mem_idx];
        mem_if.i_mem_rdata <= rd_p1;
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tot++; if (mem_if.o_mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_en got=%b want=0", mem_if.o_mem_en); end
        n_tot++; if (mem_if.o_mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_we got=%b want=0", mem_if.o_mem_we); end
        n_tot++; if (mem_if.o_mem_addr !== 20'h0) begin n_bad++; $display("FAIL rst_addr got=%h want=0", mem_if.o_mem_addr); end
        n_tot++; if (mem_if.o_mem_wdata !== 12'h0) begin n_bad++; $display("FAIL rst_wdata got=%h want=0", mem_if.o_mem_wdata); end
        n_tot++; if (wr_fifo_rd !== 1'b0) begin n_bad++; $display("FAIL rst_pop got=%b want=0", wr_fifo_rd); end
        n_tot++; if (rd_fifo_wr !== 1'b0) begin n_bad++; $display("FAIL rst_push got=%b want=0", rd_fifo_wr); end
        n_tot++; if (rd_fifo_data !== 12'h0) begin n_bad++; $display("FAIL rst_rdata got=%h want=0", rd_fifo_data); end
        n_tot++; if (wr_frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b want=0", wr_frame_done); end
        n_tot++; if (rd_bank !== 1'b0) begin n_bad++; $display("FAIL rst_rd_bank got=%b want=0", rd_bank); end
        rst = 1'b0;
    endtask

    task automatic test_wr_burst();
        logic [19:0] e_addr;
        @(negedge clk);
        wr_level = 10'd16;
        rd_free  = 10'd0;
        base0    = pop_cnt;
        @(negedge clk);
        wr_level = 10'd0;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) @(negedge clk);
            n_tot++; if (wr_fifo_rd !== (k < 16)) begin n_bad++; $display("FAIL wr1_pop k=%0d got=%b want=%b", k, wr_fifo_rd, (k < 16)); end
            n_tot++; if (mem_if.o_mem_en !== (k >= 1)) begin n_bad++; $display("FAIL wr1_en k=%0d got=%b want=%b", k, mem_if.o_mem_en, (k >= 1)); end
            n_tot++; if (mem_if.o_mem_we !== (k >= 1)) begin n_bad++; $display("FAIL wr1_we k=%0d got=%b want=%b", k, mem_if.o_mem_we, (k >= 1)); end
            if (k >= 1) begin
                e_addr = {1'b0, 19'(k - 1)};
                n_tot++; if (mem_if.o_mem_addr !== e_addr) begin n_bad++; $display("FAIL wr1_addr k=%0d got=%h want=%h", k, mem_if.o_mem_addr, e_addr); end
                n_tot++; if (mem_if.o_mem_wdata !== 12'(base0 + k - 1)) begin n_bad++; $display("FAIL wr1_wdata k=%0d got=%h want=%h", k, mem_if.o_mem_wdata, 12'(base0 + k - 1)); end
            end
        end
    endtask

    task automatic test_frame_done();
        int done_cnt = 0;
        int done_t = -1;
        int wr_cnt = 0;
        @(negedge clk);
        wr_level = 10'd16;
        for (int t = 0; t <= 60; t++) begin
            @(negedge clk);
            if (t == 36) wr_level = 10'd0;
            if (wr_frame_done === 1'b1) begin done_cnt++; done_t = t; end
            if (mem_if.o_mem_en === 1'b1 && mem_if.o_mem_we === 1'b1) wr_cnt++;
            if (t == 52) begin
                n_tot++; if (mem_if.o_mem_addr !== 20'h0003F) begin n_bad++; $display("FAIL fd_last_addr got=%h want=0003f", mem_if.o_mem_addr); end
            end
        end
        n_tot++; if (done_cnt !== 1) begin n_bad++; $display("FAIL fd_pulses got=%0d want=1", done_cnt); end
        n_tot++; if (done_t !== 53) begin n_bad++; $display("FAIL fd_time got=%0d want=53", done_t); end
        n_tot++; if (wr_cnt !== 48) begin n_bad++; $display("FAIL fd_writes got=%0d want=48", wr_cnt); end
    endtask

    task automatic test_full_discard();
        int pops = 0;
        int ens = 0;
        int dones = 0;
        @(negedge clk);
        wr_level = 10'd16;
        @(negedge clk);
        wr_level = 10'd0;
        for (int k = 0; k <= 18; k++) begin
            if (k > 0) @(negedge clk);
            if (wr_fifo_rd === 1'b1) pops++;
            if (mem_if.o_mem_en !== 1'b0) ens++;
            if (wr_frame_done !== 1'b0) dones++;
        end
        n_tot++; if (pops !== 16) begin n_bad++; $display("FAIL full_pops got=%0d want=16", pops); end
        n_tot++; if (ens !== 0) begin n_bad++; $display("FAIL full_mem_en got=%0d want=0", ens); end
        n_tot++; if (dones !== 0) begin n_bad++; $display("FAIL full_done got=%0d want=0", dones); end
    endtask

    task automatic test_back_to_back();
        logic        e_en, e_we, e_pop, e_push;
        logic [19:0] e_addr;
        logic [11:0] e_wd, e_rd;
        int k, o;
        @(negedge clk);
        wr_sof = 1'b1;
        rd_frame_req = 1'b1;
        @(negedge clk);
        wr_sof = 1'b0;
        rd_frame_req = 1'b0;
        @(negedge clk);
        n_tot++; if (rd_bank !== 1'b0) begin n_bad++; $display("FAIL swap_rd_bank got=%b want=0", rd_bank); end
        wr_level = 10'd16;
        rd_free  = 10'd16;
        for (int t = 0; t <= 73; t++) begin
            @(negedge clk);
            if (t == 0) base1 = pop_cnt;
            e_en = 1'b0; e_we = 1'b0; e_pop = 1'b0; e_push = 1'b0;
            e_addr = '0; e_wd = '0; e_rd = '0;
            if (t <= 17 || (t >= 37 && t <= 54)) begin
                k = (t <= 17) ? t : t - 37;
                o = (t <= 17) ? 0 : 16;
                if (k < 16) begin e_en = 1'b1; e_addr = {1'b0, 19'(o + k)}; end
                if (k >= 2) begin e_push = 1'b1; e_rd = 12'(base0 + o + k - 2); end
            end else if ((t >= 19 && t <= 35) || (t >= 56 && t <= 72)) begin
                k = (t <= 35) ? t - 19 : t - 56;
                o = (t <= 35) ? 0 : 16;
                e_pop = (k < 16);
                if (k >= 1) begin
                    e_en = 1'b1; e_we = 1'b1;
                    e_addr = {1'b1, 19'(o + k - 1)};
                    e_wd = 12'(base1 + o + k - 1);
                end
            end
            n_tot++; if (mem_if.o_mem_en !== e_en) begin n_bad++; $display("FAIL b2b_en t=%0d got=%b want=%b", t, mem_if.o_mem_en, e_en); end
            n_tot++; if (mem_if.o_mem_we !== e_we) begin n_bad++; $display("FAIL b2b_we t=%0d got=%b want=%b", t, mem_if.o_mem_we, e_we); end
            n_tot++; if (wr_fifo_rd !== e_pop) begin n_bad++; $display("FAIL b2b_pop t=%0d got=%b want=%b", t, wr_fifo_rd, e_pop); end
            n_tot++; if (rd_fifo_wr !== e_push) begin n_bad++; $display("FAIL b2b_push t=%0d got=%b want=%b", t, rd_fifo_wr, e_push); end
            if (e_en) begin
                n_tot++; if (mem_if.o_mem_addr !== e_addr) begin n_bad++; $display("FAIL b2b_addr t=%0d got=%h want=%h", t, mem_if.o_mem_addr, e_addr); end
            end
            if (e_we) begin
                n_tot++; if (mem_if.o_mem_wdata !== e_wd) begin n_bad++; $display("FAIL b2b_wdata t=%0d got=%h want=%h", t, mem_if.o_mem_wdata, e_wd); end
            end
            if (e_push) begin
                n_tot++; if (rd_fifo_data !== e_rd) begin n_bad++; $display("FAIL b2b_rdata t=%0d got=%h want=%h", t, rd_fifo_data, e_rd); end
            end
            if (t == 73) begin
                wr_level = 10'd0;
                rd_free  = 10'd0;
            end
        end
    endtask

    task automatic test_sof_restart();
        int dones = 0;
        logic [19:0] e_addr;
        @(negedge clk);
        wr_sof = 1'b1;
        @(negedge clk);
        wr_sof = 1'b0;
        @(negedge clk);
        wr_level = 10'd16;
        @(negedge clk);
        wr_level = 10'd0;
        for (int k = 0; k <= 18; k++) begin
            if (k > 0) @(negedge clk);
            if (wr_frame_done !== 1'b0) dones++;
            n_tot++; if (mem_if.o_mem_en !== (k >= 1 && k <= 16)) begin n_bad++; $display("FAIL sof_en k=%0d got=%b want=%b", k, mem_if.o_mem_en, (k >= 1 && k <= 16)); end
            if (k >= 1 && k <= 16) begin
                e_addr = {1'b1, 19'(k - 1)};
                n_tot++; if (mem_if.o_mem_addr !== e_addr) begin n_bad++; $display("FAIL sof_addr k=%0d got=%h want=%h", k, mem_if.o_mem_addr, e_addr); end
            end
        end
        n_tot++; if (dones !== 0) begin n_bad++; $display("FAIL sof_done got=%0d want=0", dones); end
    endtask

    task automatic test_reset_mid_burst();
        int ens = 0;
        @(negedge clk);
        rd_free = 10'd16;
        for (int k = 0; k <= 5; k++) @(negedge clk);
        n_tot++; if (mem_if.o_mem_en !== 1'b1) begin n_bad++; $display("FAIL mid_en got=%b want=1", mem_if.o_mem_en); end
        n_tot++; if (mem_if.o_mem_addr !== 20'h00025) begin n_bad++; $display("FAIL mid_addr got=%h want=00025", mem_if.o_mem_addr); end
        n_tot++; if (rd_fifo_wr !== 1'b1) begin n_bad++; $display("FAIL mid_push got=%b want=1", rd_fifo_wr); end
        rst = 1'b1;
        @(negedge clk);
        n_tot++; if (mem_if.o_mem_en !== 1'b0) begin n_bad++; $display("FAIL abort_en got=%b want=0", mem_if.o_mem_en); end
        n_tot++; if (mem_if.o_mem_we !== 1'b0) begin n_bad++; $display("FAIL abort_we got=%b want=0", mem_if.o_mem_we); end
        n_tot++; if (mem_if.o_mem_addr !== 20'h0) begin n_bad++; $display("FAIL abort_addr got=%h want=0", mem_if.o_mem_addr); end
        n_tot++; if (rd_fifo_wr !== 1'b0) begin n_bad++; $display("FAIL abort_push got=%b want=0", rd_fifo_wr); end
        n_tot++; if (rd_fifo_data !== 12'h0) begin n_bad++; $display("FAIL abort_rdata got=%h want=0", rd_fifo_data); end
        n_tot++; if (wr_fifo_rd !== 1'b0) begin n_bad++; $display("FAIL abort_pop got=%b want=0", wr_fifo_rd); end
        n_tot++; if (rd_bank !== 1'b0) begin n_bad++; $display("FAIL abort_rd_bank got=%b want=0", rd_bank); end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_if.o_mem_en !== 1'b0 || rd_fifo_wr !== 1'b0) ens++;
        end
        n_tot++; if (ens !== 0) begin n_bad++; $display("FAIL disarmed_access got=%0d want=0", ens); end
        rd_frame_req = 1'b1;
        @(negedge clk);
        rd_frame_req = 1'b0;
        @(negedge clk);
        n_tot++; if (rd_bank !== 1'b1) begin n_bad++; $display("FAIL rearm_rd_bank got=%b want=1", rd_bank); end
        @(negedge clk);
        n_tot++; if (mem_if.o_mem_en !== 1'b1 || mem_if.o_mem_we !== 1'b0) begin n_bad++; $display("FAIL rearm_read got=%b%b want=10", mem_if.o_mem_en, mem_if.o_mem_we); end
        n_tot++; if (mem_if.o_mem_addr !== 20'h80000) begin n_bad++; $display("FAIL rearm_addr got=%h want=80000", mem_if.o_mem_addr); end
        rd_free = 10'd0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        wr_sof       = 1'b0;
        wr_level     = 10'd0;
        rd_frame_req = 1'b0;
        rd_free      = 10'd0;
        test_reset();
        test_wr_burst();
        test_frame_done();
        test_full_discard();
        test_back_to_back();
        test_sof_restart();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
